// File: rtl/acc_level_tracker.sv
// Box-car averages a signed sample stream and maps the average onto threshold levels.
// Hysteresis and a multi-window debounce gate each committed level change.
module acc_level_tracker #(
  parameter int unsigned W           = 8,
  parameter int unsigned NUM_LEVELS  = 8,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned HYST        = 2,
  parameter int unsigned STABLE_CNT  = 2,
  parameter int unsigned RESET_LEVEL = 0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic signed [W-1:0]                  i_sample,
  input  logic                                 i_valid,
  input  logic                                 i_clear,
  input  logic        [(NUM_LEVELS-1)*W-1:0]   i_thr,
  output logic signed [W-1:0]                  o_avg,
  output logic        [$clog2(NUM_LEVELS)-1:0] o_level,
  output logic                                 o_level_valid,
  output logic                                 o_changed
);

  localparam int unsigned LW  = $clog2(NUM_LEVELS);
  localparam int unsigned NE  = 1 << LW;
  localparam int unsigned AW  = W + AVG_LOG2;
  localparam int unsigned CW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned XW  = W + 2;
  localparam logic signed [XW-1:0] HYST_X   = XW'(HYST);
  localparam logic        [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic signed [AW-1:0] r_acc;
  logic        [CW-1:0] r_cnt;
  logic                 r_v1;
  logic                 r_v2;
  logic        [LW-1:0] r_cand;
  logic        [LW-1:0] r_pend;
  logic        [3:0]    r_db_cnt;

  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_shift;
  logic                 w_last;
  logic signed [W-1:0]  w_thr [NE];
  logic signed [XW-1:0] w_avg_x;
  logic signed [XW-1:0] w_lo_x;
  logic signed [XW-1:0] w_hi_x;
  logic        [LW-1:0] w_raw;
  logic        [LW-1:0] w_cand;
  logic        [LW-1:0] w_pend_n;
  logic        [LW-1:0] w_level_n;
  logic        [3:0]    w_db_cnt_n;
  logic                 w_commit;

  assign w_sum   = r_acc + AW'(i_sample);
  assign w_shift = w_sum >>> AVG_LOG2;
  assign w_last  = (r_cnt == CNT_LAST);

  // Accumulator and stage 1 (window average)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_v1  <= 1'b0;
      o_avg <= '0;
    end else begin
      r_v1 <= 1'b0;
      if (i_clear) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (i_valid) begin
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
          o_avg <= W'(w_shift);
          r_v1  <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  // Unused table entries beyond the last threshold read as zero
  always_comb begin
    for (int k = 0; k < int'(NE); k++) w_thr[k] = '0;
    for (int k = 0; k < int'(NUM_LEVELS) - 1; k++) w_thr[k] = i_thr[k*W +: W];
  end

  assign w_avg_x = XW'(o_avg);
  assign w_lo_x  = XW'(w_thr[LW'(o_level - LW'(1))]) + HYST_X;
  assign w_hi_x  = XW'(w_thr[o_level]) - HYST_X;

  // Stage 2: raw level (smallest exceeded threshold) and hysteresis
  always_comb begin
    w_raw = LW'(NUM_LEVELS - 1);
    for (int k = int'(NUM_LEVELS) - 2; k >= 0; k--) begin
      if (w_avg_x > XW'(w_thr[k])) w_raw = LW'(k);
    end
    w_cand = o_level;
    if (w_raw < o_level) begin
      if (w_avg_x > w_lo_x) w_cand = w_raw;
    end else if (w_raw > o_level) begin
      if (w_avg_x <= w_hi_x) w_cand = w_raw;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v2   <= 1'b0;
      r_cand <= LW'(RESET_LEVEL);
    end else begin
      r_v2 <= r_v1;
      if (r_v1) r_cand <= w_cand;
    end
  end

  // Stage 3: debounce across consecutive windows
  always_comb begin
    w_pend_n   = r_pend;
    w_db_cnt_n = r_db_cnt;
    w_level_n  = o_level;
    w_commit   = 1'b0;
    if (r_v2) begin
      if (r_cand == o_level) begin
        w_db_cnt_n = '0;
      end else if (r_cand == r_pend) begin
        if (r_db_cnt + 4'd1 == 4'(STABLE_CNT)) begin
          w_level_n  = r_pend;
          w_db_cnt_n = '0;
          w_commit   = 1'b1;
        end else begin
          w_db_cnt_n = r_db_cnt + 4'd1;
        end
      end else begin
        w_pend_n = r_cand;
        if (STABLE_CNT == 1) begin
          w_level_n  = r_cand;
          w_db_cnt_n = '0;
          w_commit   = 1'b1;
        end else begin
          w_db_cnt_n = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_level       <= LW'(RESET_LEVEL);
      r_pend        <= LW'(RESET_LEVEL);
      r_db_cnt      <= '0;
      o_level_valid <= 1'b0;
      o_changed     <= 1'b0;
    end else begin
      o_level       <= w_level_n;
      r_pend        <= w_pend_n;
      r_db_cnt      <= w_db_cnt_n;
      o_level_valid <= r_v2;
      o_changed     <= w_commit;
    end
  end

endmodule

// File: tb/tb_acc_level_tracker.sv
// Directed bench for acc_level_tracker: table of 4-sample windows plus clear/reset sequences.
module tb_acc_level_tracker;

  localparam int unsigned W  = 8;
  localparam int unsigned NL = 8;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic signed [W-1:0]   i_sample;
  logic                  i_valid;
  logic                  i_clear;
  logic [(NL-1)*W-1:0]   i_thr;
  logic signed [W-1:0]   o_avg;
  logic [2:0]            o_level;
  logic                  o_level_valid;
  logic                  o_changed;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int s0, s1, s2, s3;
    int avg;
    int lvl;
    int ch;
  } vec_t;

  vec_t t1[11];
  vec_t t2[7];
  vec_t t3[2];

  acc_level_tracker dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sample(i_sample), .i_valid(i_valid),
    .i_clear(i_clear), .i_thr(i_thr), .o_avg(o_avg), .o_level(o_level),
    .o_level_valid(o_level_valid), .o_changed(o_changed)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive one window on consecutive cycles, then check N+1..N+4
  task automatic run_window(input vec_t v);
    int s[4];
    s[0] = v.s0; s[1] = v.s1; s[2] = v.s2; s[3] = v.s3;
    for (int i = 0; i < 4; i++) begin
      i_sample = W'(s[i]);
      i_valid  = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    check("avg_n1", int'(o_avg), v.avg);
    check("valid_n1", int'(o_level_valid), 0);
    tick();
    check("valid_n2", int'(o_level_valid), 0);
    tick();
    check("valid_n3", int'(o_level_valid), 1);
    check("level_n3", int'(o_level), v.lvl);
    check("changed_n3", int'(o_changed), v.ch);
    tick();
    check("valid_n4", int'(o_level_valid), 0);
    check("changed_n4", int'(o_changed), 0);
  endtask

  initial begin
    t1[0]  = '{30, 30, 30, 30, 30, 0, 0};
    t1[1]  = '{30, 30, 30, 30, 30, 2, 1};
    t1[2]  = '{41, 41, 41, 41, 41, 2, 0};
    t1[3]  = '{41, 41, 41, 41, 41, 2, 0};
    t1[4]  = '{43, 43, 43, 43, 43, 2, 0};
    t1[5]  = '{43, 43, 43, 43, 43, 1, 1};
    t1[6]  = '{-1, -1, -1, -2, -2, 1, 0};
    t1[7]  = '{-128, -128, -128, -128, -128, 1, 0};
    t1[8]  = '{-128, -128, -128, -128, -128, 7, 1};
    t1[9]  = '{127, 127, 127, 127, 127, 7, 0};
    t1[10] = '{127, 127, 127, 127, 127, 0, 1};

    t2[0] = '{30, 30, 30, 30, 30, 0, 0};
    t2[1] = '{30, 30, 30, 30, 30, 2, 1};
    t2[2] = '{10, 10, 10, 10, 10, 2, 0};
    t2[3] = '{-10, -10, -10, -10, -10, 2, 0};
    t2[4] = '{10, 10, 10, 10, 10, 2, 0};
    t2[5] = '{-10, -10, -10, -10, -10, 2, 0};
    t2[6] = '{10, 10, 10, 10, 10, 2, 0};

    t3[0] = '{30, 30, 30, 30, 30, 0, 0};
    t3[1] = '{30, 30, 30, 30, 30, 2, 1};

    i_thr    = {8'(-60), 8'(-40), 8'(-20), 8'(0), 8'(20), 8'(40), 8'(60)};
    i_rst    = 1'b1;
    i_sample = '0;
    i_valid  = 1'b0;
    i_clear  = 1'b0;
    repeat (3) tick();
    i_rst = 1'b0;
    check("rst_level", int'(o_level), 0);
    check("rst_avg", int'(o_avg), 0);
    check("rst_valid", int'(o_level_valid), 0);
    check("rst_changed", int'(o_changed), 0);
    tick();

    for (int i = 0; i < 11; i++) run_window(t1[i]);

    // Partial window discarded by clear; the clear-cycle sample is dropped
    for (int i = 0; i < 2; i++) begin
      i_sample = 8'sd100;
      i_valid  = 1'b1;
      tick();
    end
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    i_valid = 1'b0;
    run_window('{0, 0, 0, 0, 0, 0, 0});

    for (int i = 0; i < 7; i++) run_window(t2[i]);

    // Reset lands on the edge that would commit level 3
    for (int i = 0; i < 4; i++) begin
      i_sample = 8'sd10;
      i_valid  = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    check("pre_rst_avg", int'(o_avg), 10);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("midrst_level", int'(o_level), 0);
    check("midrst_valid", int'(o_level_valid), 0);
    check("midrst_changed", int'(o_changed), 0);
    check("midrst_avg", int'(o_avg), 0);
    tick();
    check("midrst_valid2", int'(o_level_valid), 0);
    check("midrst_changed2", int'(o_changed), 0);

    for (int i = 0; i < 2; i++) run_window(t3[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
